// File: rtl/method_caller_01_if.sv
// Method-call bus between the caller (master) and the callee (slave).
// Master drives start/result/check arguments and the start/check enables; the slave
// returns the ready flags and the result/check return values.
//   start_a, start_b : start() arguments          stenable  : start() enable
//   result_c         : result() argument          result    : result() return value
//   check_d          : check() argument           chenable  : check() enable
//   check            : check() return value       RDY_*     : callee ready per method
interface method_caller_01_if #(
  parameter int unsigned WIDTH = 5
) ();
  logic [WIDTH-1:0] start_a;
  logic [WIDTH-1:0] start_b;
  logic             stenable;
  logic             RDY_start;
  logic [WIDTH-1:0] result_c;
  logic [WIDTH-1:0] result;
  logic             RDY_result;
  logic [WIDTH-1:0] check_d;
  logic [WIDTH-1:0] check;
  logic             chenable;
  logic             RDY_check;

  modport master (
    output start_a, start_b, stenable, result_c, check_d, chenable,
    input  RDY_start, result, RDY_result, check, RDY_check
  );

  modport slave (
    input  start_a, start_b, stenable, result_c, check_d, chenable,
    output RDY_start, result, RDY_result, check, RDY_check
  );
endinterface

// File: rtl/method_caller_01.sv
// Initiator for the start/result/check method interface. On go it runs NUM_TXN
// transactions: start(a,b), wait for result and capture it, then check(d) with the
// captured value and compare the returned value. Counts passes and failures.
// Ports:
//   CLK, RST  : clock and synchronous active-high reset
//   go        : run request, sampled only while idle
//   m         : method bus (master side)
//   busy      : run in progress (includes the done cycle)
//   done      : one-cycle pulse at end of run
//   pass_cnt  : transactions whose check matched (saturating)
//   fail_cnt  : transactions that mismatched or timed out (saturating)
module method_caller_01 #(
  parameter int unsigned      WIDTH   = 5,
  parameter int unsigned      NUM_TXN = 8,
  parameter int unsigned      TIMEOUT = 15,
  parameter logic [WIDTH-1:0] SEED    = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                go,
  method_caller_01_if.master  m,
  output logic                busy,
  output logic                done,
  output logic [7:0]          pass_cnt,
  output logic [7:0]          fail_cnt
);

  typedef enum logic [2:0] {
    StIdle, StStart, StWaitr, StCheck, StPass, StFail, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d, op_next;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [7:0]       txn_q, txn_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [7:0]       pass_q, pass_d;
  logic [7:0]       fail_q, fail_d;
  logic             rdy_wait;
  logic             tmo;

  if (WIDTH == 5) begin : g_lfsr
    // Fibonacci LFSR, taps 5 and 3.
    assign op_next = {op_q[3:0], op_q[4] ^ op_q[2]};
  end else begin : g_inc
    logic [WIDTH-1:0] op_inc;
    assign op_inc  = op_q + WIDTH'(1);
    assign op_next = (op_inc == '0) ? WIDTH'(1) : op_inc;
  end

  // Last permitted wait cycle with the awaited RDY still low.
  assign tmo = (wcnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    exp_d    = exp_q;
    txn_d    = txn_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    rdy_wait = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          pass_d  = '0;
          fail_d  = '0;
          txn_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        rdy_wait = m.RDY_start;
        if (m.RDY_start) state_d = StWaitr;
        else if (tmo)    state_d = StFail;
      end
      StWaitr: begin
        rdy_wait = m.RDY_result;
        if (m.RDY_result) begin
          exp_d   = m.result;
          state_d = StCheck;
        end else if (tmo) begin
          state_d = StFail;
        end
      end
      StCheck: begin
        rdy_wait = m.RDY_check;
        if (m.RDY_check) state_d = (m.check == exp_q) ? StPass : StFail;
        else if (tmo)    state_d = StFail;
      end
      StPass, StFail: begin
        if (state_q == StPass) pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
        else                   fail_d = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;
        txn_d = txn_q + 8'd1;
        if (txn_q == 8'(NUM_TXN - 1)) begin
          state_d = StDone;
        end else begin
          op_d    = op_next;
          state_d = StStart;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Restart the wait count on every state entry; count cycles the awaited RDY is low.
    wcnt_d = (state_d != state_q) ? 8'd0 : wcnt_q + {7'd0, ~rdy_wait};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      op_q    <= SEED;
      exp_q   <= '0;
      txn_q   <= '0;
      wcnt_q  <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      exp_q   <= exp_d;
      txn_q   <= txn_d;
      wcnt_q  <= wcnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // Outputs decode the state register only, so enables behave as registered signals.
  always_comb begin
    m.stenable = (state_q == StStart);
    m.chenable = (state_q == StCheck);
    m.start_a  = (state_q == StStart) ? op_q : '0;
    m.start_b  = (state_q == StStart) ? ~op_q : '0;
    m.result_c = (state_q == StWaitr) ? (op_q ^ WIDTH'(txn_q)) : '0;
    m.check_d  = (state_q == StCheck) ? exp_q : '0;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    pass_cnt   = pass_q;
    fail_cnt   = fail_q;
  end

endmodule

// File: tb/tb_method_caller_01.sv
module tb_method_caller_01;
  localparam int W  = 5;
  localparam int N  = 8;
  localparam int TO = 15;
  localparam logic [W-1:0] SEED = 5'h01;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       go  = 1'b0;
  logic       busy, done;
  logic [7:0] pass_cnt, fail_cnt;

  method_caller_01_if #(.WIDTH(W)) bus ();

  method_caller_01 #(
    .WIDTH(W), .NUM_TXN(N), .TIMEOUT(TO), .SEED(SEED)
  ) dut (
    .CLK(CLK), .RST(RST), .go(go), .m(bus),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Per-transaction callee behaviour: cycles each RDY stays low, result value, bad check.
  int         ds[N], dr[N], dc[N];
  logic [W-1:0] rv[N];
  bit         bad[N];

  logic [W-1:0] m_op;
  int tidx, first_start, done_cyc, cyc, stlen, rcnt, ccnt, chen_total;
  bit wr;

  function automatic logic [W-1:0] lfsr(input logic [W-1:0] v);
    return {v[3:0], v[4] ^ v[2]};
  endfunction

  function automatic int ti();
    return (tidx < 0) ? 0 : (tidx > N - 1) ? N - 1 : tidx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-run totals from the transaction rules.
  task automatic predict(output int pe, output int fe, output int le, output int ce);
    pe = 0; fe = 0; le = 0; ce = 0;
    for (int t = 0; t < N; t++) begin
      if (ds[t] >= TO) begin
        le += TO + 1; fe++;
      end else if (dr[t] >= TO) begin
        le += ds[t] + 1 + TO + 1; fe++;
      end else begin
        le += ds[t] + 1 + dr[t] + 1;
        ce += (dc[t] >= TO) ? TO : dc[t] + 1;
        if (dc[t] >= TO) begin
          le += TO + 1; fe++;
        end else begin
          le += dc[t] + 2;
          if (bad[t]) fe++; else pe++;
        end
      end
    end
  endtask

  // One clock: advance, sample #1 after the edge, check, and drive the callee's answers.
  task automatic tick();
    bit pst, fire;
    logic [W-1:0] nb;
    pst  = (bus.stenable === 1'b1);
    fire = (bus.stenable === 1'b1) && (bus.RDY_start === 1'b1);
    @(posedge CLK);
    #1;
    cyc++;
    chk("st_ch_excl", 32'(bus.stenable & bus.chenable), 0);
    if (bus.stenable === 1'b1) begin
      if (!pst) begin
        tidx++;
        if (tidx > 0) m_op = lfsr(m_op);
        if (first_start < 0) first_start = cyc;
        nb = ~m_op;
        chk("start_a", bus.start_a, m_op);
        chk("start_b", bus.start_b, nb);
        stlen = 0;
      end
      bus.RDY_start = (stlen >= ds[ti()]);
      stlen++;
    end else begin
      if (pst) chk("st_len", stlen, (ds[ti()] >= TO) ? TO : ds[ti()] + 1);
      bus.RDY_start = 1'b0;
    end
    if (fire) begin
      wr = 1'b1;
      rcnt = 0;
    end
    if (bus.stenable === 1'b1 || bus.chenable === 1'b1 || busy !== 1'b1 || done === 1'b1)
      wr = 1'b0;
    if (wr && rcnt < TO) chk("result_c", bus.result_c, m_op ^ 5'(tidx));
    bus.RDY_result = wr && (rcnt >= dr[ti()]);
    bus.result = bus.RDY_result ? rv[ti()] : 5'($urandom);
    if (wr) rcnt++;
    if (bus.chenable === 1'b1) begin
      chk("check_d", bus.check_d, rv[ti()]);
      bus.RDY_check = (ccnt >= dc[ti()]);
      bus.check = !bus.RDY_check ? 5'($urandom) : bad[ti()] ? (rv[ti()] ^ 5'h01) : rv[ti()];
      ccnt++;
      chen_total++;
    end else begin
      ccnt = 0;
      bus.RDY_check = 1'b0;
      bus.check = 5'($urandom);
    end
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic set_all(input int s, input int r, input int c, input logic [W-1:0] v);
    for (int t = 0; t < N; t++) begin
      ds[t] = s; dr[t] = r; dc[t] = c; rv[t] = v; bad[t] = 1'b0;
    end
  endtask

  function automatic int pick();
    int r;
    r = $urandom_range(0, 7);
    return (r < 4) ? r : (r == 4) ? 13 : (r == 5) ? 14 : (r == 6) ? 15 : 17;
  endfunction

  task automatic rand_fill();
    for (int t = 0; t < N; t++) begin
      ds[t] = pick(); dr[t] = pick(); dc[t] = pick();
      rv[t] = 5'($urandom);
      bad[t] = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic do_run(input bit hold_go);
    int pe, fe, le, ce;
    predict(pe, fe, le, ce);
    tidx = -1; first_start = -1; done_cyc = -1; chen_total = 0;
    go = 1'b1;
    tick();
    if (!hold_go) go = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_stenable", bus.stenable, 1);
    chk("clr_pass", pass_cnt, 0);
    chk("clr_fail", fail_cnt, 0);
    for (int i = 0; i < 3000 && done_cyc < 0; i++) tick();
    chk("done_seen", done_cyc >= 0, 1);
    chk("done_busy", busy, 1);
    chk("txn_cnt", tidx + 1, N);
    chk("pass_cnt", pass_cnt, pe);
    chk("fail_cnt", fail_cnt, fe);
    chk("run_len", done_cyc - first_start, le);
    chk("chen_cycles", chen_total, ce);
    tick();
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_pass", pass_cnt, pe);
    chk("hold_fail", fail_cnt, fe);
  endtask

  task automatic chk_zero();
    chk("z_stenable", bus.stenable, 0);
    chk("z_chenable", bus.chenable, 0);
    chk("z_start_a", bus.start_a, 0);
    chk("z_start_b", bus.start_b, 0);
    chk("z_result_c", bus.result_c, 0);
    chk("z_check_d", bus.check_d, 0);
    chk("z_busy", busy, 0);
    chk("z_done", done, 0);
    chk("z_pass", pass_cnt, 0);
    chk("z_fail", fail_cnt, 0);
  endtask

  initial begin
    bus.RDY_start = 1'b0; bus.RDY_result = 1'b0; bus.RDY_check = 1'b0;
    bus.result = '0; bus.check = '0;
    m_op = SEED; tidx = -1; cyc = 0; wr = 1'b0; stlen = 0; rcnt = 0; ccnt = 0;
    first_start = -1; done_cyc = -1; chen_total = 0;
    set_all(0, 0, 0, 5'h0A);

    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    chk_zero();

    // Always ready, constant answers: 8 passes in 32 cycles.
    set_all(0, 0, 0, 5'h0A);
    do_run(1'b0);

    // One corrupted check return.
    set_all(0, 0, 0, 5'h0A);
    bad[3] = 1'b1;
    do_run(1'b0);

    // start never ready: every transaction times out in START.
    set_all(40, 0, 0, 5'h0A);
    do_run(1'b0);

    // Timeout boundaries on each wait.
    set_all(0, 0, 0, 5'h15);
    ds[0] = 14; ds[1] = 15; dr[2] = 14; dr[3] = 15; dc[4] = 14; dc[5] = 15; bad[6] = 1'b1;
    do_run(1'b0);

    // Reset while check is enabled.
    set_all(0, 0, 30, 5'h07);
    tidx = -1; first_start = -1; done_cyc = -1;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 20 && bus.chenable !== 1'b1; i++) tick();
    chk("reach_check", bus.chenable, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    m_op = SEED;
    chk_zero();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_quiet", {30'd0, bus.stenable, bus.chenable}, 0);
    end

    // go held through two runs; operand continues across runs.
    set_all(0, 0, 0, 5'h0A);
    do_run(1'b1);
    chk("restart_go_held", go, 1);
    rand_fill();
    do_run(1'b0);

    for (int k = 0; k < 3; k++) begin
      rand_fill();
      do_run(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/method_caller_01.md
Name: method_caller_01

Overview:
- Initiator-side driver for the start/result/check method interface of the mkDesign_01-style design-under-test. It is the caller that drives enables and arguments into the callee.
- On `go`, issues NUM_TXN transactions. Each transaction:
  - calls start(a,b);
  - waits for result, then samples result(c);
  - calls check(d) with the sampled result and compares the returned value.
- Accumulates pass/fail counts; used as a self-checking stimulus engine in port-renaming and enable tests.

Parameters:
- WIDTH, 5, width of every data argument and return value.
- NUM_TXN, 8, transactions per run (1..255).
- TIMEOUT, 15, maximum cycles to wait on any RDY before aborting the transaction (1..255).
- SEED, 5'h01, initial operand value for start_a; must be nonzero.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- go  in  1  level; sampled only in IDLE; starts a run.
- start_a  out  WIDTH  argument a of start.
- start_b  out  WIDTH  argument b of start.
- stenable  out  1  enable for start.
- RDY_start  in  1  callee ready for start.
- result_c  out  WIDTH  argument c of the result value method.
- result  in  WIDTH  return value of result.
- RDY_result  in  1  result valid.
- check_d  out  WIDTH  argument d of check.
- check  in  WIDTH  return value of check, valid in the cycle chenable && RDY_check.
- chenable  out  1  enable for check.
- RDY_check  in  1  callee ready for check.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pass_cnt  out  8  transactions whose check matched.
- fail_cnt  out  8  transactions that mismatched or timed out.

Behaviour:
- Reset (RST=1 at a clock edge):
  - state=IDLE; all outputs 0.
  - Operand register op=SEED; txn counter=0; wait counter=0.
  - Reset mid-run aborts immediately. No enable is asserted in the following cycle.
- Operands:
  - start_a = op; start_b = ~op; result_c = op ^ txn[WIDTH-1:0].
  - After each transaction (pass or fail), op advances by a Fibonacci LFSR for WIDTH=5 (taps 5,3).
  - For other widths, op advances by op+1, wrapping to 1 on reaching 0.
- Arguments are driven only in the states that use them. start_a/start_b/result_c/check_d are 0 otherwise.
- Method-fire rule: a method fires in a cycle with enable=1 && RDY=1.
  - Enables are registered outputs.
  - An enable stays asserted until the method fires or times out; it is then deasserted in the next cycle.
- States:
  - IDLE: busy=0. If go=1: clear pass_cnt/fail_cnt, txn=0, go to START.
  - START: stenable=1. On fire, go to WAITR. If the wait counter reaches TIMEOUT first, go to FAIL.
  - WAITR: stenable=0.
    - On RDY_result=1: capture exp=result and go to CHECK.
    - On TIMEOUT: go to FAIL.
    - The capture occurs in the first cycle RDY_result is seen, never in the same cycle start fired.
  - CHECK: chenable=1, check_d=exp. On fire, compare check against exp. Match goes to PASS; mismatch goes to FAIL. TIMEOUT goes to FAIL.
  - PASS / FAIL (1 cycle each): increment the corresponding counter, saturating at 8'hFF; then txn++.
    - If txn==NUM_TXN-1 before the increment, go to DONE.
    - Otherwise advance op and go to START.
  - DONE (1 cycle): done=1, busy=1. Next state is IDLE. Counters hold until the next go.
- Wait counter:
  - Clears on every state entry and increments each cycle the awaited RDY is low.
  - Timeout fires when the counter equals TIMEOUT-1 with RDY still low. Total wait is therefore TIMEOUT cycles.
  - RDY high in the same cycle as the timeout wins: the method fires, no timeout.
- Back-to-back: a DUT that is always ready gives a minimum of 4 cycles per transaction (START, WAITR, CHECK, PASS).
- go while busy is ignored. go held high after DONE starts a new run on the IDLE cycle.
- Invariant: stenable and chenable are never both 1.

Test Plan:
- All RDY tied 1; DUT returns result=check=constant 5'h0A; go pulse.
  - Required: 8 transactions, 32 cycles from the first START to done.
  - Required: pass_cnt=8, fail_cnt=0.
  - Required: the first start_a=5'h01, start_b=5'h1E.
- As above, but check returns exp^1 on transaction 3 only.
  - Required: pass_cnt=7, fail_cnt=1; that transaction's check_d equals its captured result.
- RDY_start held low.
  - Required: each transaction holds stenable for exactly 15 cycles, then fails.
  - Required: fail_cnt=8; chenable never asserted.
- RDY_result rises on the exact cycle the wait counter hits 14.
  - Required: no timeout, transaction passes.
- RST asserted while in CHECK with chenable=1.
  - Required: the next cycle has all outputs 0, state IDLE, counters 0; no further enable until a new go.
- go held high through two runs.
  - Required: a done pulse, then one IDLE cycle, then a restart with counters cleared.
  - Required: op continues from the LFSR value rather than SEED.
